// File: rtl/arcade_io_event_device_pkg.sv
// Shared constants and helpers for the arcade I/O event device.
// Event and command byte codes, parameter legality checks, event byte encoder.
// No ports; imported by the device top and its sub-modules.
package arcade_io_pkg;

  // Event bytes: press reports an upper-case letter, release a lower-case one.
  localparam logic [7:0] EVT_PRESS_BASE   = 8'h41;
  localparam logic [7:0] EVT_RELEASE_BASE = 8'h61;

  // Host command bytes received on the CDC OUT channel.
  localparam logic [7:0] CMD_ENABLE  = 8'h45;
  localparam logic [7:0] CMD_DISABLE = 8'h44;
  localparam logic [7:0] CMD_RESYNC  = 8'h52;

  // One letter per input, so at most 26 inputs.
  function automatic bit num_inputs_ok(input int n);
    return (n >= 1) && (n <= 26);
  endfunction

  function automatic bit debounce_ok(input int n);
    return (n >= 2) && (n <= 32);
  endfunction

  function automatic bit fifo_depth_ok(input int d);
    return (d >= 2) && ((d & (d - 1)) == 0);
  endfunction

  function automatic logic [7:0] evt_byte(input logic pressed, input logic [4:0] idx);
    return (pressed ? EVT_PRESS_BASE : EVT_RELEASE_BASE) + {3'b000, idx};
  endfunction

endpackage

// File: rtl/arcade_io_event_device_if.sv
// USB_CDC byte channels between the event device and the CDC core.
// IN: device -> host event bytes (valid/ready). OUT: host -> device commands.
// master = event device side, slave = CDC core side.
interface arcade_io_event_device_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/arcade_event_fifo.sv
// Synchronous 8-bit event FIFO with flush, full/empty flags and occupancy.
// Latency: a pushed byte is visible on pop_data_o the cycle after the push.
// Backpressure: push while full is dropped unless a pop happens in the same cycle.
// Ports: clk_i/rst_i, flush_i, push_i/push_data_i, pop_i/pop_data_o, full_o, empty_o, level_o.
module arcade_event_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [7:0]               push_data_i,
  input  logic                     pop_i,
  output logic [7:0]               pop_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        do_push, do_pop;

  assign do_pop  = pop_i && !empty_o;
  // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

  assign pop_data_o = mem_q[rd_ptr_q[AW-1:0]];
  assign level_o    = wr_ptr_q - rd_ptr_q;
  assign empty_o    = (wr_ptr_q == rd_ptr_q);
  assign full_o     = (level_o == LW'(DEPTH));
endmodule

// File: rtl/arcade_io_event_device.sv
// Debounces button lines, scans them round-robin and queues press/release letters to USB_CDC IN.
// Latency: a debounced change reaches in_data at most NUM_INPUTS+2 cycles later (empty FIFO, ready high).
// Backpressure: FIFO absorbs IN stalls; when full the scanner stalls on the changed input, coalescing toggles.
// Ports: clk_i, rst_i, inputs_i (raw buttons), frame_i (USB frame), usb_configured_i,
//        enabled_o, fifo_level_o, bus (IN event bytes / OUT command bytes).
module arcade_io_event_device
  import arcade_io_pkg::*;
#(
  parameter int NUM_INPUTS  = 16,
  parameter int DEBOUNCE_MS = 10,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_INPUTS-1:0]         inputs_i,
  input  logic [10:0]                   frame_i,
  input  logic                          usb_configured_i,
  output logic                          enabled_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  arcade_io_event_device_if.master      bus
);
  localparam int IW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

  if (!num_inputs_ok(NUM_INPUTS) || !debounce_ok(DEBOUNCE_MS) || !fifo_depth_ok(FIFO_DEPTH)) begin : g_bad_params
    $error("arcade_io_event_device: parameter out of legal range");
  end

  // Only bit 0 of the frame number carries the 1 ms tick.
  logic unused_frame;
  assign unused_frame = ^frame_i[10:1];

  logic [NUM_INPUTS-1:0] sync1_q, sync2_q;
  logic                  frame_q, beat_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
      frame_q <= 1'b0;
      beat_q  <= 1'b0;
    end else begin
      sync1_q <= inputs_i;
      sync2_q <= sync1_q;
      frame_q <= frame_i[0];
      beat_q  <= frame_i[0] ^ frame_q;
    end
  end

  // Per-input debounce: the level only moves once DEBOUNCE_MS consecutive
  // 1 ms samples agree; anything shorter is treated as bounce.
  logic [NUM_INPUTS-1:0] deb_w;

  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_deb
    logic [DEBOUNCE_MS-1:0] hist_q, hist_d;
    logic                   lvl_q;

    assign hist_d = {hist_q[DEBOUNCE_MS-2:0], sync2_q[i]};

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        hist_q <= '0;
        lvl_q  <= 1'b0;
      end else if (beat_q) begin
        hist_q <= hist_d;
        if (&hist_d)       lvl_q <= 1'b1;
        else if (~|hist_d) lvl_q <= 1'b0;
      end
    end

    assign deb_w[i] = lvl_q;
  end

  logic [IW-1:0]         idx_q;
  logic [NUM_INPUTS-1:0] last_q;
  logic                  enabled_q, resync_q, out_ready_q, in_valid_q;
  logic [7:0]            in_data_q;

  logic       fifo_full, fifo_empty;
  logic [7:0] fifo_rd;
  logic       scan_active, cur_lvl, changed, pop, can_push, push, advance, cmd_acc;
  logic [IW-1:0] idx_next;

  // The scanner sits out the cycle a resync is applied so it cannot push
  // against last_queued bits that are about to be cleared.
  assign scan_active = enabled_q && usb_configured_i && !resync_q;
  assign cur_lvl     = deb_w[idx_q];
  assign changed     = (cur_lvl != last_q[idx_q]);
  assign pop         = usb_configured_i && !fifo_empty && (!in_valid_q || bus.in_ready);
  assign can_push    = !fifo_full || pop;
  assign push        = scan_active && changed && can_push;
  assign advance     = scan_active && (!changed || can_push);
  assign idx_next    = (idx_q == IW'(NUM_INPUTS - 1)) ? '0 : idx_q + 1'b1;
  assign cmd_acc     = bus.out_valid && out_ready_q;

  arcade_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (!usb_configured_i),
    .push_i      (push),
    .push_data_i (evt_byte(cur_lvl, 5'(idx_q))),
    .pop_i       (pop),
    .pop_data_o  (fifo_rd),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .level_o     (fifo_level_o)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx_q       <= '0;
      last_q      <= '0;
      enabled_q   <= 1'b1;
      resync_q    <= 1'b0;
      out_ready_q <= 1'b0;
      in_valid_q  <= 1'b0;
      in_data_q   <= 8'h00;
    end else begin
      out_ready_q <= 1'b1;

      // Commands land at the end of the accepting cycle, so a push made in
      // that same cycle always completes under the old settings.
      if (cmd_acc) begin
        case (bus.out_data)
          CMD_ENABLE:  enabled_q <= 1'b1;
          CMD_DISABLE: enabled_q <= 1'b0;
          default:     ;
        endcase
      end
      resync_q <= cmd_acc && (bus.out_data == CMD_RESYNC);

      if (!usb_configured_i || resync_q) begin
        idx_q  <= '0;
        last_q <= '0;
      end else if (advance) begin
        idx_q <= idx_next;
        if (push) last_q[idx_q] <= cur_lvl;
      end

      if (!usb_configured_i) begin
        in_valid_q <= 1'b0;
      end else if (pop) begin
        in_data_q  <= fifo_rd;
        in_valid_q <= 1'b1;
      end else if (bus.in_ready) begin
        in_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_data   = in_data_q;
  assign bus.in_valid  = in_valid_q;
  assign bus.out_ready = out_ready_q;
  assign enabled_o     = enabled_q;
endmodule

// File: tb/tb_arcade_io_event_device.sv
module tb_arcade_io_event_device;
  import arcade_io_pkg::*;

  localparam int NI        = 16;
  localparam int DB        = 10;
  localparam int FD        = 8;
  localparam int LW        = $clog2(FD) + 1;
  localparam int FRAME_CYC = 24;
  localparam int SETTLE_FR = 13;

  logic          clk = 1'b0;
  logic          rst;
  logic [NI-1:0] inputs;
  logic [10:0]   frame;
  logic          cfg;
  logic          enabled;
  logic [LW-1:0] level;

  arcade_io_event_device_if bus();

  arcade_io_event_device #(.NUM_INPUTS(NI), .DEBOUNCE_MS(DB), .FIFO_DEPTH(FD)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .inputs_i         (inputs),
    .frame_i          (frame),
    .usb_configured_i (cfg),
    .enabled_o        (enabled),
    .fifo_level_o     (level),
    .bus              (bus)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference model: held button levels, levels last reported to the host,
  // and the reporting/configured state as seen from the host side.
  logic [NI-1:0] held_m, rep_m;
  bit            en_m, cfg_m;
  logic [7:0]    got_q[$];
  int            rdy_mode;
  int            stab_err;
  bit            watch_lvl, lvl_nz;

  // Host side sink and hold-stability monitor.
  bit         prev_ok, prev_vld, prev_rdy;
  logic [7:0] prev_dat;
  always @(negedge clk) begin
    if (!rst && bus.in_valid && bus.in_ready) got_q.push_back(bus.in_data);
    if (!rst && cfg && prev_ok && prev_vld && !prev_rdy)
      if (!bus.in_valid || bus.in_data !== prev_dat) stab_err++;
    prev_ok  = !rst && cfg;
    prev_vld = bus.in_valid;
    prev_rdy = bus.in_ready;
    prev_dat = bus.in_data;
    if (watch_lvl && level != 0) lvl_nz = 1'b1;
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       bus.in_ready = 1'b0;
        1:       bus.in_ready = 1'b1;
        default: bus.in_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin
    frame = '0;
    forever begin
      repeat (FRAME_CYC) @(posedge clk);
      #1 frame = frame + 1'b1;
    end
  end

  initial begin
    #1500000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_frames(input int n);
    tick(n * FRAME_CYC);
  endtask

  task automatic set_held(input logic [NI-1:0] v);
    held_m = v;
    inputs = v;
  endtask

  task automatic send_cmd(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    bus.out_data  = b;
    bus.out_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.out_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    bus.out_valid = 1'b0;
    chk("cmd_accept", 32'(ok), 32'd1);
    if (ok) begin
      if (b == CMD_ENABLE)  en_m  = 1'b1;
      if (b == CMD_DISABLE) en_m  = 1'b0;
      if (b == CMD_RESYNC)  rep_m = '0;
    end
  endtask

  function automatic int evt_idx(input logic [7:0] b);
    return (b >= EVT_RELEASE_BASE) ? int'(b - EVT_RELEASE_BASE) : int'(b - EVT_PRESS_BASE);
  endfunction

  // Every input whose held level differs from what the host last saw yields
  // one letter, in index order; reporting must be on and the link configured.
  task automatic settle(output logic [7:0] exp_q[$]);
    exp_q = {};
    if (en_m && cfg_m) begin
      for (int i = 0; i < NI; i++) begin
        if (held_m[i] != rep_m[i]) begin
          exp_q.push_back(held_m[i] ? EVT_PRESS_BASE + 8'(i) : EVT_RELEASE_BASE + 8'(i));
          rep_m[i] = held_m[i];
        end
      end
    end
  endtask

  // ordered=1: scan known to start at index 0, so exact index order.
  // ordered=0: scan starts anywhere, so each letter once in rotated index order.
  task automatic expect_events(input string tag, input bit ordered);
    logic [7:0] exp_q[$];
    bit         drained;
    int         cnt, desc;
    settle(exp_q);
    tick(40);
    drained = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (level == 0 && !bus.in_valid) begin
        drained = 1'b1;
        break;
      end
      tick(1);
    end
    chk({tag, "_drain"}, 32'(drained), 32'd1);
    chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    if (ordered) begin
      for (int k = 0; k < exp_q.size(); k++)
        chk({tag, "_byte"}, (k < got_q.size()) ? 32'(got_q[k]) : 32'hDEAD, 32'(exp_q[k]));
    end else begin
      foreach (exp_q[k]) begin
        cnt = 0;
        foreach (got_q[j]) if (got_q[j] == exp_q[k]) cnt++;
        chk({tag, "_once"}, 32'(cnt), 32'd1);
      end
      if (got_q.size() > 1) begin
        desc = 0;
        for (int j = 1; j < got_q.size(); j++)
          if (evt_idx(got_q[j]) < evt_idx(got_q[j-1])) desc++;
        chk({tag, "_order"}, 32'(desc <= 1), 32'd1);
      end
    end
    got_q.delete();
  endtask

  task automatic bounce(input string tag, input int bit_i, input int per, input int segs);
    logic [NI-1:0] v;
    v = held_m;
    for (int s = 0; s < segs; s++) begin
      v[bit_i] = ~v[bit_i];
      inputs   = v;
      wait_frames(per);
    end
    inputs = held_m;
    wait_frames(SETTLE_FR);
    expect_events(tag, 1'b0);
  endtask

  initial begin
    rst = 1'b1; inputs = '0; cfg = 1'b1;
    bus.out_valid = 1'b0; bus.out_data = 8'h00; bus.in_ready = 1'b1;
    rdy_mode = 1; stab_err = 0; watch_lvl = 1'b0; lvl_nz = 1'b0;
    held_m = '0; rep_m = '0; en_m = 1'b1; cfg_m = 1'b1;
    tick(3);
    chk("rst_in_valid", 32'(bus.in_valid), 32'd0);
    chk("rst_in_data", 32'(bus.in_data), 32'h00);
    chk("rst_enabled", 32'(enabled), 32'd1);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_out_ready", 32'(bus.out_ready), 32'd0);
    rst = 1'b0;
    tick(2);
    chk("out_ready_up", 32'(bus.out_ready), 32'd1);

    // Single press then release of input 3.
    set_held(NI'(1) << 3); wait_frames(SETTLE_FR);
    expect_events("press3", 1'b1);
    set_held('0); wait_frames(SETTLE_FR);
    expect_events("release3", 1'b1);

    // Bounce shorter than the debounce window must never reach the FIFO.
    watch_lvl = 1'b1;
    bounce("bounce0", 0, 3, 10);
    bounce("bounce_rnd", $urandom_range(0, NI - 1), $urandom_range(1, 4), 2 * $urandom_range(3, 7));
    watch_lvl = 1'b0;
    chk("bounce_level", 32'(lvl_nz), 32'd0);

    // Random button patterns under random host readiness.
    for (int r = 0; r < 6; r++) begin
      rdy_mode = (r % 2 == 0) ? 2 : 1;
      set_held((r == 5) ? '0 : NI'($urandom));
      wait_frames(SETTLE_FR);
      expect_events("rand", 1'b0);
    end

    // Overflow: ten presses into an eight-deep FIFO with the host stalled.
    rdy_mode = 0; tick(2);
    send_cmd(CMD_DISABLE);
    chk("dis_enabled", 32'(enabled), 32'd0);
    set_held(NI'(16'h03FF)); wait_frames(SETTLE_FR);
    chk("dis_no_valid", 32'(bus.in_valid), 32'd0);
    send_cmd(CMD_RESYNC);
    send_cmd(CMD_ENABLE);
    tick(40);
    chk("ovf_level", 32'(level), 32'd8);
    chk("ovf_valid", 32'(bus.in_valid), 32'd1);
    chk("ovf_data", 32'(bus.in_data), 32'h41);
    tick(30);
    chk("ovf_hold_data", 32'(bus.in_data), 32'h41);
    chk("ovf_hold_level", 32'(level), 32'd8);
    rdy_mode = 1;
    expect_events("ovf", 1'b1);

    // Disable, enable and resync with inputs 1 and 5.
    set_held('0); wait_frames(SETTLE_FR);
    expect_events("rel_all", 1'b0);
    set_held(NI'(16'h0022)); wait_frames(SETTLE_FR);
    expect_events("p1p5", 1'b0);
    send_cmd(CMD_DISABLE);
    set_held(NI'(16'h0020)); wait_frames(SETTLE_FR);
    expect_events("dis_quiet", 1'b1);
    send_cmd(CMD_ENABLE);
    chk("en_enabled", 32'(enabled), 32'd1);
    expect_events("en_b", 1'b1);
    send_cmd(CMD_RESYNC);
    expect_events("resync_f", 1'b1);

    // Unconfigure with events pending.
    rdy_mode = 0;
    set_held(NI'(16'h1AA4) | held_m); wait_frames(SETTLE_FR);
    chk("ucfg_level", 32'(level), 32'd4);
    chk("ucfg_valid", 32'(bus.in_valid), 32'd1);
    cfg = 1'b0; cfg_m = 1'b0; rep_m = '0;
    tick(5);
    chk("ucfg_flush", 32'(level), 32'd0);
    chk("ucfg_drop", 32'(bus.in_valid), 32'd0);
    got_q.delete();
    cfg = 1'b1; cfg_m = 1'b1; rdy_mode = 1;
    expect_events("recfg", 1'b1);

    // Asynchronous reset in the middle of a stalled transfer.
    rdy_mode = 0;
    send_cmd(CMD_RESYNC);
    tick(40);
    chk("pre_rst_valid", 32'(bus.in_valid), 32'd1);
    send_cmd(CMD_DISABLE);
    #3 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(bus.in_valid), 32'd0);
    chk("arst_enabled", 32'(enabled), 32'd1);
    chk("arst_level", 32'(level), 32'd0);
    chk("arst_out_ready", 32'(bus.out_ready), 32'd0);
    rep_m = '0; en_m = 1'b1;
    got_q.delete();
    rdy_mode = 1;
    tick(3);
    rst = 1'b0;
    wait_frames(SETTLE_FR);
    expect_events("post_rst", 1'b0);

    chk("stable_hold", 32'(stab_err), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
